// File: rtl/if_pkg.sv
// Shared definitions for the instruction-fetch next-PC logic.
//   IF_XLEN / IF_NSRC     default PC width and redirect-source count
//   IF_RESET_PC           default PC after reset
//   IF_TRAP_VEC           default misalignment trap target
//   SRC_EX_TA/ALU/ID_TA   redirect source indices (0 = highest priority)
//   if_pend_t             pending-redirect entry {target, src} at default widths
//   src_width()           index width for an N-source encoder (minimum 1 bit)
package if_pkg;

  localparam int unsigned IF_XLEN = 32;
  localparam int unsigned IF_NSRC = 3;

  localparam logic [IF_XLEN-1:0] IF_RESET_PC = '0;
  localparam logic [IF_XLEN-1:0] IF_TRAP_VEC = '0;

  localparam int unsigned SRC_EX_TA  = 0;
  localparam int unsigned SRC_EX_ALU = 1;
  localparam int unsigned SRC_ID_TA  = 2;

  function automatic int unsigned src_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  localparam int unsigned IF_SRC_W = src_width(IF_NSRC);

  typedef struct packed {
    logic [IF_XLEN-1:0]  target;
    logic [IF_SRC_W-1:0] src;
  } if_pend_t;

endpackage

// File: rtl/if_redir_prio_enc.sv
// Fixed-priority encoder over the redirect request vector.
//   req   in   NSRC   per-source request bits
//   any   out  1      at least one request asserted
//   idx   out  SW     lowest asserted index (0 when none)
module if_redir_prio_enc
  import if_pkg::*;
#(
  parameter int unsigned NSRC = IF_NSRC,
  parameter int unsigned SW   = src_width(NSRC)
) (
  input  logic [NSRC-1:0] req,
  output logic            any,
  output logic [SW-1:0]   idx
);

  always_comb begin
    any = 1'b0;
    idx = '0;
    for (int unsigned i = 0; i < NSRC; i++) begin
      if (req[i] && !any) begin
        any = 1'b1;
        idx = SW'(i);
      end
    end
  end

endmodule

// File: rtl/if_next_pc_unit.sv
// Fetch-stage PC register and next-PC selection.
//   clk, rst_n     rising-edge clock, asynchronous active-low reset
//   stall          hold PC this cycle; redirects arriving meanwhile are buffered
//   redir_valid    per-source redirect request (index 0 = highest priority)
//   redir_target   source i target at [i*XLEN +: XLEN]
//   pc             current fetch PC (registered)
//   pc_plus        pc + INC, combinational, wraps modulo 2^XLEN
//   redir_taken    PC was loaded from a redirect on the last edge
//   redir_src      index of the last applied redirect source
//   pend_valid     one-entry pending-redirect buffer occupied
//   misalign       one-cycle trap flag for a misaligned redirect target
// Optional feature: define IF_PC_MISALIGN_TRAP_EN to divert misaligned redirect
// targets to TRAP_VEC and raise misalign; otherwise targets load verbatim and
// misalign is constant 0.
module if_next_pc_unit
  import if_pkg::*;
#(
  parameter int unsigned        XLEN     = IF_XLEN,
  parameter int unsigned        NSRC     = IF_NSRC,
  parameter int unsigned        INC      = 4,
  parameter logic [XLEN-1:0]    RESET_PC = XLEN'(IF_RESET_PC),
  parameter logic [XLEN-1:0]    TRAP_VEC = XLEN'(IF_TRAP_VEC),
  localparam int unsigned       SW       = src_width(NSRC)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 stall,
  input  logic [NSRC-1:0]      redir_valid,
  input  logic [NSRC*XLEN-1:0] redir_target,
  output logic [XLEN-1:0]      pc,
  output logic [XLEN-1:0]      pc_plus,
  output logic                 redir_taken,
  output logic [SW-1:0]        redir_src,
  output logic                 pend_valid,
  output logic                 misalign
);

  typedef struct packed {
    logic [XLEN-1:0] target;
    logic [SW-1:0]   src;
  } pend_t;

  logic [XLEN-1:0] pc_q, pc_d;
  logic            taken_q, taken_d;
  logic [SW-1:0]   src_q, src_d;
  logic            pend_valid_q, pend_valid_d;
  pend_t           pend_q, pend_d;

  logic            win_valid;
  logic [SW-1:0]   win_idx;
  logic [XLEN-1:0] tgt_arr [NSRC];
  logic [XLEN-1:0] win_tgt;

  logic            cand_valid;
  logic [XLEN-1:0] cand_tgt;
  logic [SW-1:0]   cand_src;
  logic            cand_bad;

  if_redir_prio_enc #(
    .NSRC (NSRC),
    .SW   (SW)
  ) u_prio (
    .req (redir_valid),
    .any (win_valid),
    .idx (win_idx)
  );

  always_comb begin
    for (int unsigned i = 0; i < NSRC; i++) begin
      tgt_arr[i] = redir_target[i*XLEN +: XLEN];
    end
  end

  assign win_tgt = tgt_arr[win_idx];
  assign pc_plus = pc_q + XLEN'(INC);

  // A buffered redirect survives a new request only when the new source has
  // strictly lower priority (larger index); ties go to the newer request.
  always_comb begin
    cand_valid = 1'b0;
    cand_tgt   = '0;
    cand_src   = '0;
    if (pend_valid_q && (!win_valid || (win_idx > pend_q.src))) begin
      cand_valid = 1'b1;
      cand_tgt   = pend_q.target;
      cand_src   = pend_q.src;
    end else if (win_valid) begin
      cand_valid = 1'b1;
      cand_tgt   = win_tgt;
      cand_src   = win_idx;
    end
  end

`ifdef IF_PC_MISALIGN_TRAP_EN
  assign cand_bad = cand_valid && ((cand_tgt % XLEN'(INC)) != '0);
`else
  assign cand_bad = 1'b0;
`endif

  always_comb begin
    pc_d         = pc_q;
    taken_d      = 1'b0;
    src_d        = src_q;
    pend_valid_d = pend_valid_q;
    pend_d       = pend_q;
    if (!stall) begin
      pend_valid_d = 1'b0;
      taken_d      = cand_valid;
      if (cand_valid) begin
        pc_d  = cand_bad ? TRAP_VEC : cand_tgt;
        src_d = cand_src;
      end else begin
        pc_d  = pc_plus;
      end
    end else if (cand_valid) begin
      pend_valid_d  = 1'b1;
      pend_d.target = cand_tgt;
      pend_d.src    = cand_src;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_q         <= RESET_PC;
      taken_q      <= 1'b0;
      src_q        <= '0;
      pend_valid_q <= 1'b0;
      pend_q       <= '0;
    end else begin
      pc_q         <= pc_d;
      taken_q      <= taken_d;
      src_q        <= src_d;
      pend_valid_q <= pend_valid_d;
      pend_q       <= pend_d;
    end
  end

`ifdef IF_PC_MISALIGN_TRAP_EN
  logic misalign_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      misalign_q <= 1'b0;
    end else begin
      misalign_q <= !stall && cand_bad;
    end
  end

  assign misalign = misalign_q;
`else
  assign misalign = 1'b0;
`endif

  assign pc          = pc_q;
  assign redir_taken = taken_q;
  assign redir_src   = src_q;
  assign pend_valid  = pend_valid_q;

endmodule

// File: tb/tb_if_next_pc_unit.sv
module tb_if_next_pc_unit;

  localparam logic [31:0] TRAP = 32'h0000_0800;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        stall;
  logic [2:0]  rv;
  logic [95:0] rt;
  logic [31:0] pc, pc_plus;
  logic        redir_taken, pend_valid, misalign;
  logic [1:0]  redir_src;

  int tests = 0;
  int fails = 0;

  // reference state
  logic [31:0] m_pc;
  logic        m_taken, m_pend, m_mis;
  int          m_src, m_pend_src;
  logic [31:0] m_pend_tgt;

  if_next_pc_unit #(
    .XLEN     (32),
    .NSRC     (3),
    .INC      (4),
    .RESET_PC (32'h0),
    .TRAP_VEC (TRAP)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .stall        (stall),
    .redir_valid  (rv),
    .redir_target (rt),
    .pc           (pc),
    .pc_plus      (pc_plus),
    .redir_taken  (redir_taken),
    .redir_src    (redir_src),
    .pend_valid   (pend_valid),
    .misalign     (misalign)
  );

  always #5 clk = ~clk;

  task automatic model_reset();
    m_pc = 32'h0; m_taken = 0; m_src = 0; m_pend = 0; m_mis = 0;
    m_pend_src = 0; m_pend_tgt = 0;
  endtask

  // One clock edge: the reference applies the rules to the inputs present
  // before the edge, then outputs are sampled 1ns later.
  task automatic tick();
    int          win;
    bit          have;
    logic [31:0] ctgt;
    int          csrc;
    @(posedge clk);
    if (!rst_n) begin
      model_reset();
    end else begin
      win = -1;
      for (int i = 2; i >= 0; i--) if (rv[i]) win = i;
      have = 1;
      if (m_pend && (win < 0 || win > m_pend_src)) begin
        ctgt = m_pend_tgt; csrc = m_pend_src;
      end else if (win >= 0) begin
        ctgt = rt[win*32 +: 32]; csrc = win;
      end else begin
        have = 0; ctgt = 0; csrc = 0;
      end
      m_mis = 0;
      if (!stall) begin
        m_pend  = 0;
        m_taken = have;
        if (have) begin
          m_src = csrc;
`ifdef IF_PC_MISALIGN_TRAP_EN
          if (ctgt % 4 != 0) begin m_pc = TRAP; m_mis = 1; end
          else m_pc = ctgt;
`else
          m_pc = ctgt;
`endif
        end else begin
          m_pc = m_pc + 32'd4;
        end
      end else begin
        m_taken = 0;
        if (have) begin m_pend = 1; m_pend_tgt = ctgt; m_pend_src = csrc; end
      end
    end
    #1;
  endtask

  task automatic set_tgt(input int i, input logic [31:0] v);
    rt[i*32 +: 32] = v;
  endtask

  task automatic test_reset();
    rst_n = 1; stall = 0; rv = 0; rt = '0;
    tick(); tick(); tick();
    #2 rst_n = 0; #1;
    model_reset();
    tests++; if (pc !== 32'h0) begin fails++; $display("FAIL reset_pc: got %h expected %h", pc, 32'h0); end
    tests++; if ({redir_taken, redir_src, pend_valid, misalign} !== 5'b0) begin
      fails++; $display("FAIL reset_flags: got %b expected 00000", {redir_taken, redir_src, pend_valid, misalign});
    end
    tick();
    #2 rst_n = 1;
    tick();
  endtask

  task automatic test_sequential();
    rv = 3'b001; set_tgt(0, 32'h100); tick();
    tests++; if (pc !== 32'h100) begin fails++; $display("FAIL seq_load: got %h expected %h", pc, 32'h100); end
    rv = 0;
    for (int k = 1; k <= 4; k++) begin
      tick();
      tests++; if (pc !== 32'h100 + 32'(4*k)) begin
        fails++; $display("FAIL seq_step%0d: got %h expected %h", k, pc, 32'h100 + 32'(4*k));
      end
    end
    tests++; if (redir_taken !== 1'b0) begin fails++; $display("FAIL seq_taken: got %b expected 0", redir_taken); end
  endtask

  task automatic test_priority();
    rv = 3'b110; set_tgt(1, 32'h200); set_tgt(2, 32'h300); tick();
    rv = 0;
    tests++; if (pc !== 32'h200) begin fails++; $display("FAIL prio_pc: got %h expected %h", pc, 32'h200); end
    tests++; if (redir_src !== 2'd1) begin fails++; $display("FAIL prio_src: got %0d expected 1", redir_src); end
    tests++; if (redir_taken !== 1'b1) begin fails++; $display("FAIL prio_taken: got %b expected 1", redir_taken); end
  endtask

  task automatic test_stall_buffer();
    logic [31:0] held;
    held = m_pc;
    stall = 1; rv = 3'b100; set_tgt(2, 32'h400); tick();
    rv = 0;
    for (int k = 0; k < 2; k++) tick();
    tests++; if (pc !== held) begin fails++; $display("FAIL stall_hold: got %h expected %h", pc, held); end
    tests++; if (pend_valid !== 1'b1) begin fails++; $display("FAIL stall_pend: got %b expected 1", pend_valid); end
    tests++; if (redir_taken !== 1'b0) begin fails++; $display("FAIL stall_taken: got %b expected 0", redir_taken); end
    stall = 0; tick();
    tests++; if (pc !== 32'h400) begin fails++; $display("FAIL stall_release_pc: got %h expected %h", pc, 32'h400); end
    tests++; if (redir_src !== 2'd2) begin fails++; $display("FAIL stall_release_src: got %0d expected 2", redir_src); end
    tests++; if (pend_valid !== 1'b0) begin fails++; $display("FAIL stall_release_pend: got %b expected 0", pend_valid); end
  endtask

  task automatic test_override();
    stall = 1; rv = 3'b100; set_tgt(2, 32'h400); tick();
    rv = 3'b001; set_tgt(0, 32'h500); tick();
    rv = 0; stall = 0; tick();
    tests++; if (pc !== 32'h500 || redir_src !== 2'd0) begin
      fails++; $display("FAIL override_fwd: got pc=%h src=%0d expected pc=500 src=0", pc, redir_src);
    end
    stall = 1; rv = 3'b001; set_tgt(0, 32'h500); tick();
    rv = 3'b100; set_tgt(2, 32'h400); tick();
    rv = 0; stall = 0; tick();
    tests++; if (pc !== 32'h500 || redir_src !== 2'd0) begin
      fails++; $display("FAIL override_rev: got pc=%h src=%0d expected pc=500 src=0", pc, redir_src);
    end
  endtask

  task automatic test_wrap();
    rv = 3'b001; set_tgt(0, 32'hFFFF_FFFC); tick();
    rv = 0;
    tests++; if (pc_plus !== 32'h0) begin fails++; $display("FAIL wrap_plus: got %h expected 0", pc_plus); end
    tick();
    tests++; if (pc !== 32'h0) begin fails++; $display("FAIL wrap_pc: got %h expected 0", pc); end
  endtask

  task automatic test_misalign();
    rv = 3'b001; set_tgt(0, 32'h202); tick();
    rv = 0;
`ifdef IF_PC_MISALIGN_TRAP_EN
    tests++; if (pc !== TRAP || misalign !== 1'b1 || redir_src !== 2'd0) begin
      fails++; $display("FAIL misalign_trap: got pc=%h mis=%b src=%0d expected pc=%h mis=1 src=0", pc, misalign, redir_src, TRAP);
    end
    tick();
    tests++; if (misalign !== 1'b0) begin fails++; $display("FAIL misalign_pulse: got %b expected 0", misalign); end
`else
    tests++; if (pc !== 32'h202 || misalign !== 1'b0) begin
      fails++; $display("FAIL misalign_off: got pc=%h mis=%b expected pc=202 mis=0", pc, misalign);
    end
    tick();
    tests++; if (pc !== 32'h206) begin fails++; $display("FAIL misalign_seq: got %h expected 206", pc); end
`endif
  endtask

  task automatic test_reset_mid_stall();
    stall = 1; rv = 3'b010; set_tgt(1, 32'h0000_0ABC); tick();
    rv = 0;
    tests++; if (pend_valid !== 1'b1) begin fails++; $display("FAIL rst_stall_pend: got %b expected 1", pend_valid); end
    #2 rst_n = 0; #1;
    model_reset();
    tests++; if (pend_valid !== 1'b0 || pc !== 32'h0) begin
      fails++; $display("FAIL rst_stall_clear: got pend=%b pc=%h expected pend=0 pc=0", pend_valid, pc);
    end
    tick();
    #2 rst_n = 1; stall = 0;
    tick();
    tests++; if (pc !== 32'h4 || redir_taken !== 1'b0) begin
      fails++; $display("FAIL rst_stall_after: got pc=%h taken=%b expected pc=4 taken=0", pc, redir_taken);
    end
  endtask

  task automatic test_random();
    int bad;
    for (int n = 0; n < 400; n++) begin
      stall = ($urandom_range(0, 9) < 3);
      rv    = ($urandom_range(0, 1) == 0) ? 3'b000 : 3'($urandom_range(1, 7));
      for (int i = 0; i < 3; i++) begin
        logic [31:0] t;
        t = $urandom;
        if ($urandom_range(0, 7) != 0) t[1:0] = 2'b00;
        set_tgt(i, t);
      end
      tick();
      bad = 0;
      if (pc !== m_pc) bad = 1;
      if (pc_plus !== m_pc + 32'd4) bad = 1;
      if (redir_taken !== m_taken) bad = 1;
      if (redir_src !== 2'(m_src)) bad = 1;
      if (pend_valid !== m_pend) bad = 1;
      if (misalign !== m_mis) bad = 1;
      tests++;
      if (bad != 0) begin
        fails++;
        $display("FAIL random[%0d]: got pc=%h tk=%b src=%0d pend=%b mis=%b expected pc=%h tk=%b src=%0d pend=%b mis=%b",
                 n, pc, redir_taken, redir_src, pend_valid, misalign, m_pc, m_taken, m_src, m_pend, m_mis);
      end
    end
    stall = 0; rv = 0;
  endtask

  initial begin
    rst_n = 0; stall = 0; rv = 0; rt = '0;
    model_reset();
    #12;
    test_reset();
    test_sequential();
    test_priority();
    test_stall_buffer();
    test_override();
    test_wrap();
    test_misalign();
    test_reset_mid_stall();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
